instr_mem_sync: RTL and testbench

- Parametrised, clocked instruction memory for the MIPS32 fetch stage.
- Replaces the combinational word-indexed ROM with a registered read, a valid/ready fetch handshake with back-pressure, and byte- or word-address decoding.
- Returns NOP with an error flag on misaligned or out-of-range fetches.
- Has a program-load port that lets the testbench or boot logic rewrite instruction words at run time, with fetch suspended during loading.

---
 rtl/instr_mem_sync.sv | 106 ++++++++++
 tb/tb_instr_mem_sync.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// Clocked MIPS32 instruction memory: registered fetch with valid/ready back-pressure,
// byte or word address decode with error responses, and a run-time program-load port.
module instr_mem_sync #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       DEPTH     = 1024,
  parameter int unsigned       ADDR_W    = 32,
  parameter bit                BYTE_ADDR = 1'b1,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0,
  parameter int unsigned       IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_out,
  output logic              fetch_err,
  input  logic              instr_stall,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [IDX_W-1:0]  prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ack
);

  typedef enum logic [0:0] {StRun, StProg} state_e;

  state_e state_q, state_d;

  // Contents survive reset; only the time-zero image is NOP-filled.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP_WORD};

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  idx;
  logic              misaligned;
  logic              out_of_range;
  logic              accept;
  logic              prog_write;

  logic              valid_d;
  logic [DATA_W-1:0] out_d;
  logic              err_d;

  // Full-width compare so high address bits can never alias into the array.
  always_comb begin
    word_addr    = BYTE_ADDR ? (fetch_addr >> 2) : fetch_addr;
    idx          = word_addr[IDX_W-1:0];
    misaligned   = BYTE_ADDR && (fetch_addr[1:0] != 2'b00);
    out_of_range = ({1'b0, word_addr} >= (ADDR_W + 1)'(DEPTH));
  end

  assign fetch_ready = (state_q == StRun) && (!instr_valid || !instr_stall);
  assign accept      = fetch_req && fetch_ready;
  assign prog_write  = (state_q == StProg) && prog_we;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (prog_en)  state_d = StProg;
      StProg:  if (!prog_en) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    valid_d = instr_valid;
    out_d   = instr_out;
    err_d   = fetch_err;
    if (accept) begin
      valid_d = 1'b1;
      if (misaligned || out_of_range) begin
        out_d = NOP_WORD;
        err_d = 1'b1;
      end else begin
        out_d = mem[idx];
        err_d = 1'b0;
      end
    end else if (instr_valid && !instr_stall) begin
      // Consumed with nothing new: instr_out keeps its last word.
      valid_d = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRun;
      instr_valid <= 1'b0;
      instr_out   <= NOP_WORD;
      fetch_err   <= 1'b0;
      prog_ack    <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_valid <= valid_d;
      instr_out   <= out_d;
      fetch_err   <= err_d;
      prog_ack    <= prog_write;
    end
  end

  always_ff @(posedge clk) begin
    if (prog_write) mem[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: directed scenarios plus randomized fetch traffic checked
// against an array-based memory model; a second instance covers word addressing.
module tb_instr_mem_sync;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        fetch_ready;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic        fetch_err;
  logic        instr_stall = 1'b0;
  logic        prog_en = 1'b0;
  logic        prog_we = 1'b0;
  logic [9:0]  prog_addr = '0;
  logic [31:0] prog_data = '0;
  logic        prog_ack;

  logic        w_fetch_req = 1'b0;
  logic [31:0] w_fetch_addr = '0;
  logic        w_fetch_ready;
  logic        w_instr_valid;
  logic [31:0] w_instr_out;
  logic        w_fetch_err;
  logic        w_prog_en = 1'b0;
  logic        w_prog_we = 1'b0;
  logic [9:0]  w_prog_addr = '0;
  logic [31:0] w_prog_data = '0;
  logic        w_prog_ack;

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [1024];

  instr_mem_sync #(
    .DATA_W(32), .DEPTH(1024), .ADDR_W(32), .BYTE_ADDR(1'b1), .NOP_WORD(NOP)
  ) u_dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr_out(instr_out), .fetch_err(fetch_err),
    .instr_stall(instr_stall),
    .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .prog_ack(prog_ack)
  );

  instr_mem_sync #(
    .DATA_W(32), .DEPTH(1024), .ADDR_W(32), .BYTE_ADDR(1'b0), .NOP_WORD(NOP)
  ) u_word (
    .clk(clk), .rst(rst),
    .fetch_req(w_fetch_req), .fetch_addr(w_fetch_addr), .fetch_ready(w_fetch_ready),
    .instr_valid(w_instr_valid), .instr_out(w_instr_out), .fetch_err(w_fetch_err),
    .instr_stall(1'b0),
    .prog_en(w_prog_en), .prog_we(w_prog_we), .prog_addr(w_prog_addr),
    .prog_data(w_prog_data), .prog_ack(w_prog_ack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Byte-addressed reference: word-aligned and below DEPTH words, else NOP with error.
  function automatic void ref_fetch(input logic [31:0] a, output logic [31:0] d,
                                    output logic e);
    if ((a % 4) != 0 || (a / 4) >= 1024) begin
      d = NOP;
      e = 1'b1;
    end else begin
      d = model_mem[a / 4];
      e = 1'b0;
    end
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    logic        e;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got %b want 0", instr_valid); end
    checks++; if (instr_out !== NOP) begin errors++;
      $display("FAIL reset_out got %h want %h", instr_out, NOP); end
    checks++; if (fetch_err !== 1'b0 || prog_ack !== 1'b0) begin errors++;
      $display("FAIL reset_err_ack got %b%b want 00", fetch_err, prog_ack); end
    rst = 1'b0;
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    ref_fetch(32'h0, d, e);
    step();
    fetch_req = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_out !== d || fetch_err !== e) begin errors++;
      $display("FAIL reset_read got v%b %h e%b want v1 %h e%b",
               instr_valid, instr_out, fetch_err, d, e); end
    step();
  endtask

  task automatic test_program();
    logic [31:0] words [3];
    words[0] = 32'h8C01_03FE; words[1] = 32'hAC01_03FF; words[2] = 32'h0800_0000;
    prog_en = 1'b1;
    step();
    fetch_req = 1'b1; fetch_addr = 32'h0;
    #1;
    checks++; if (fetch_ready !== 1'b0) begin errors++;
      $display("FAIL prog_fetch_ready got %b want 0", fetch_ready); end
    step();
    fetch_req = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL prog_no_fetch got valid %b want 0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      prog_we = 1'b1; prog_addr = 10'(i); prog_data = words[i];
      model_mem[i] = words[i];
      step();
      prog_we = 1'b0;
      checks++; if (prog_ack !== 1'b1) begin errors++;
        $display("FAIL prog_ack_%0d got %b want 1", i, prog_ack); end
      step();
      checks++; if (prog_ack !== 1'b0) begin errors++;
        $display("FAIL prog_ack_clear_%0d got %b want 0", i, prog_ack); end
    end
    prog_en = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic        e;
    fetch_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_addr = 32'(i * 4);
      ref_fetch(fetch_addr, d, e);
      step();
      checks++; if (instr_valid !== 1'b1 || instr_out !== d || fetch_err !== e) begin
        errors++;
        $display("FAIL b2b_%0d got v%b %h e%b want v1 %h e%b",
                 i, instr_valid, instr_out, fetch_err, d, e); end
    end
    fetch_req = 1'b0;
    step();
    checks++; if (instr_valid !== 1'b0 || instr_out !== d) begin errors++;
      $display("FAIL drain got v%b %h want v0 %h", instr_valid, instr_out, d); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic        e;
    fetch_req = 1'b1; fetch_addr = 32'h4;
    step();
    instr_stall = 1'b1; fetch_addr = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (fetch_ready !== 1'b0) begin errors++;
        $display("FAIL stall_ready_%0d got %b want 0", i, fetch_ready); end
      step();
      checks++; if (instr_valid !== 1'b1 || instr_out !== 32'hAC01_03FF) begin errors++;
        $display("FAIL stall_hold_%0d got v%b %h want v1 ac0103ff",
                 i, instr_valid, instr_out); end
    end
    instr_stall = 1'b0;
    #1;
    checks++; if (fetch_ready !== 1'b1) begin errors++;
      $display("FAIL release_ready got %b want 1", fetch_ready); end
    ref_fetch(32'h8, d, e);
    step();
    fetch_req = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_out !== d) begin errors++;
      $display("FAIL release_fetch got v%b %h want v1 %h", instr_valid, instr_out, d); end
    step();
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    addrs[0] = 32'h6; addrs[1] = 32'h1000; addrs[2] = 32'hFFFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      fetch_req = 1'b1; fetch_addr = addrs[i];
      step();
      checks++; if (instr_valid !== 1'b1 || instr_out !== NOP || fetch_err !== 1'b1) begin
        errors++;
        $display("FAIL err_%h got v%b %h e%b want v1 %h e1",
                 addrs[i], instr_valid, instr_out, fetch_err, NOP); end
    end
    fetch_req = 1'b0;
    step();
    checks++; if (instr_valid !== 1'b0 || fetch_err !== 1'b0) begin errors++;
      $display("FAIL err_drain got v%b e%b want v0 e0", instr_valid, fetch_err); end
  endtask

  task automatic test_run_write_ignored();
    prog_we = 1'b1; prog_addr = 10'd5; prog_data = 32'h1234_5678;
    step();
    prog_we = 1'b0;
    checks++; if (prog_ack !== 1'b0) begin errors++;
      $display("FAIL run_we_ack got %b want 0", prog_ack); end
    fetch_req = 1'b1; fetch_addr = 32'h14;
    step();
    fetch_req = 1'b0;
    checks++; if (instr_out !== NOP || fetch_err !== 1'b0) begin errors++;
      $display("FAIL run_we_read got %h e%b want %h e0", instr_out, fetch_err, NOP); end
    step();
  endtask

  task automatic test_prog_entry_pending();
    logic [31:0] d;
    logic        e;
    fetch_req = 1'b1; fetch_addr = 32'h0; prog_en = 1'b1; instr_stall = 1'b1;
    ref_fetch(32'h0, d, e);
    step();
    fetch_req = 1'b0;
    checks++; if (instr_valid !== 1'b1 || instr_out !== d) begin errors++;
      $display("FAIL entry_fetch got v%b %h want v1 %h", instr_valid, instr_out, d); end
    step();
    checks++; if (instr_valid !== 1'b1 || fetch_ready !== 1'b0) begin errors++;
      $display("FAIL entry_hold got v%b r%b want v1 r0", instr_valid, fetch_ready); end
    instr_stall = 1'b0;
    step();
    checks++; if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL entry_consume got v%b want 0", instr_valid); end
    prog_en = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic        exp_valid = 1'b0;
    logic [31:0] exp_out = '0;
    logic        exp_err = 1'b0;
    logic [31:0] d;
    logic        e;
    int          r;
    prog_en = 1'b1;
    step();
    for (int i = 32; i < 40; i++) begin
      prog_we = 1'b1; prog_addr = 10'(i); prog_data = $urandom;
      model_mem[i] = prog_data;
      step();
    end
    prog_we = 1'b0; prog_en = 1'b0;
    step();
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      fetch_addr = (32'($urandom_range(28, 43)) << 2) + 32'($urandom_range(1, 3));
      else if (r == 1) fetch_addr = 32'h1000 + (32'($urandom_range(0, 5000)) << 2);
      else             fetch_addr = 32'($urandom_range(28, 43)) << 2;
      fetch_req   = ($urandom_range(0, 3) != 0);
      instr_stall = ($urandom_range(0, 3) == 0);
      #1;
      checks++; if (fetch_ready !== (!exp_valid || !instr_stall)) begin errors++;
        $display("FAIL rnd_ready_%0d got %b want %b", n, fetch_ready,
                 (!exp_valid || !instr_stall)); end
      if (fetch_req && (!exp_valid || !instr_stall)) begin
        ref_fetch(fetch_addr, d, e);
        exp_valid = 1'b1; exp_out = d; exp_err = e;
      end else if (exp_valid && !instr_stall) begin
        exp_valid = 1'b0; exp_err = 1'b0;
      end
      step();
      checks++;
      if (instr_valid !== exp_valid || (exp_valid && (instr_out !== exp_out ||
          fetch_err !== exp_err))) begin
        errors++;
        $display("FAIL rnd_resp_%0d got v%b %h e%b want v%b %h e%b", n, instr_valid,
                 instr_out, fetch_err, exp_valid, exp_out, exp_err);
      end
    end
    fetch_req = 1'b0; instr_stall = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_stall();
    fetch_req = 1'b1; fetch_addr = 32'h0;
    step();
    fetch_req = 1'b0; instr_stall = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++;
      $display("FAIL stall_reset got v%b want 0", instr_valid); end
    @(negedge clk);
    rst = 1'b0; instr_stall = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_prog();
    logic [31:0] d;
    logic        e;
    prog_en = 1'b1;
    step();
    for (int i = 10; i < 12; i++) begin
      prog_we = 1'b1; prog_addr = 10'(i); prog_data = $urandom;
      model_mem[i] = prog_data;
      step();
    end
    prog_we = 1'b0;
    #2 rst = 1'b1; prog_en = 1'b0;
    #1;
    checks++; if (prog_ack !== 1'b0 || instr_valid !== 1'b0 || instr_out !== NOP) begin
      errors++;
      $display("FAIL prog_reset got ack%b v%b %h want ack0 v0 %h",
               prog_ack, instr_valid, instr_out, NOP); end
    checks++; if (fetch_ready !== 1'b1) begin errors++;
      $display("FAIL prog_reset_ready got %b want 1", fetch_ready); end
    @(negedge clk);
    rst = 1'b0;
    fetch_req = 1'b1;
    for (int i = 10; i < 12; i++) begin
      fetch_addr = 32'(i * 4);
      ref_fetch(fetch_addr, d, e);
      step();
      checks++; if (instr_valid !== 1'b1 || instr_out !== d || fetch_err !== 1'b0) begin
        errors++;
        $display("FAIL persist_%0d got v%b %h e%b want v1 %h e0",
                 i, instr_valid, instr_out, fetch_err, d); end
    end
    fetch_req = 1'b0;
    step();
  endtask

  task automatic test_word_mode();
    logic [31:0] word_val;
    word_val = $urandom | 32'h1;
    w_prog_en = 1'b1;
    step();
    w_prog_we = 1'b1; w_prog_addr = 10'd1023; w_prog_data = word_val;
    step();
    w_prog_we = 1'b0; w_prog_en = 1'b0;
    checks++; if (w_prog_ack !== 1'b1) begin errors++;
      $display("FAIL word_ack got %b want 1", w_prog_ack); end
    step();
    w_fetch_req = 1'b1; w_fetch_addr = 32'd1024;
    step();
    checks++; if (w_instr_valid !== 1'b1 || w_fetch_err !== 1'b1 || w_instr_out !== NOP) begin
      errors++;
      $display("FAIL word_oor got v%b e%b %h want v1 e1 %h",
               w_instr_valid, w_fetch_err, w_instr_out, NOP); end
    w_fetch_addr = 32'h0001_03FF;
    step();
    checks++; if (w_fetch_err !== 1'b1) begin errors++;
      $display("FAIL word_upper got e%b want 1", w_fetch_err); end
    w_fetch_addr = 32'd1023;
    step();
    w_fetch_req = 1'b0;
    checks++; if (w_instr_out !== word_val || w_fetch_err !== 1'b0) begin errors++;
      $display("FAIL word_last got %h e%b want %h e0", w_instr_out, w_fetch_err, word_val); end
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) model_mem[i] = NOP;
    test_reset();
    test_program();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_run_write_ignored();
    test_prog_entry_pending();
    test_random();
    test_reset_mid_stall();
    test_reset_mid_prog();
    test_word_mode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
